fbuf_port_arbiter: RTL and testbench

- Shares one single-port framebuffer BRAM between two requesters:
  - scanout reads, driven by the fbuf2rgb address stream, with absolute priority;
  - a pixel writer (drawing engine / CPU bridge) using a valid/ready handshake.
- Implements double buffering. The writer always targets the back page, scanout always reads the front page.
- Page flips are requested by the writer and applied only at the start of vertical blanking (eof rising edge), so no frame tears.

---
 rtl/fbuf_pkg.sv | 18 +
 rtl/fbuf_flip_ctrl.sv | 64 ++++++
 rtl/fbuf_port_arbiter.sv | 114 +++++++++++
 tb/tb_fbuf_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbuf_pkg.sv
// Shared types and helpers for the framebuffer port arbiter and its flip controller.
package fbuf_pkg;

    typedef enum logic {
        FLIP_IDLE  = 1'b0,
        FLIP_ARMED = 1'b1
    } flip_state_e;

    localparam int PAGE_SIZE_640X480 = 307200;
    localparam int PAGE_SIZE_320X240 = 76800;

    // Scanout uses the front page, the writer the back page; single-buffer mode pins page 0.
    function automatic logic page_sel(input logic front_page, input logic is_write,
                                      input logic double_buffer);
        return double_buffer & (is_write ? ~front_page : front_page);
    endfunction

endpackage

// File: rtl/fbuf_flip_ctrl.sv
// Page flip controller: eof rising-edge detect plus the IDLE/ARMED flip FSM.
module fbuf_flip_ctrl
    import fbuf_pkg::*;
#(
    parameter int DOUBLE_BUFFER = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic eof,
    input  logic flip_req,
    output logic front_page,
    output logic flip_pending,
    output logic flip_done
);

    flip_state_e state_q, state_d;
    logic        eof_q;
    logic        front_page_q, front_page_d;
    logic        flip_done_d;
    logic        eof_rise;

    assign eof_rise = eof && !eof_q;

    // eof_q resets high so blanking already in progress at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FLIP_IDLE;
            eof_q        <= 1'b1;
            front_page_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            eof_q        <= eof;
            front_page_q <= front_page_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        front_page_d = front_page_q;
        flip_done_d  = 1'b0;
        case (state_q)
            FLIP_IDLE: begin
                if (flip_req) begin
                    state_d = FLIP_ARMED;
                end
            end
            FLIP_ARMED: begin
                if (eof_rise) begin
                    state_d     = FLIP_IDLE;
                    flip_done_d = 1'b1;
                    if (DOUBLE_BUFFER != 0) begin
                        front_page_d = ~front_page_q;
                    end
                end
            end
            default: state_d = FLIP_IDLE;
        endcase
    end

    assign front_page   = front_page_q;
    assign flip_pending = (state_q == FLIP_ARMED);
    assign flip_done    = flip_done_d && !rst;

endmodule

// File: rtl/fbuf_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: scanout reads with absolute priority, back-page writer, double buffering.
module fbuf_port_arbiter
    import fbuf_pkg::*;
#(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int PIXEL_WIDTH     = 24,
    parameter int PAGE_SIZE       = PAGE_SIZE_640X480,
    parameter int DOUBLE_BUFFER   = 1,
    parameter int READ_LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FBUF_ADDR_WIDTH-1:0] rd_addr,
    input  logic                       rd_addr_valid,
    input  logic                       eof,
    output logic [PIXEL_WIDTH-1:0]     rd_data,
    output logic                       rd_data_valid,
    input  logic [FBUF_ADDR_WIDTH-1:0] wr_addr,
    input  logic [PIXEL_WIDTH-1:0]     wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic                       wr_err,
    input  logic                       flip_req,
    output logic                       flip_pending,
    output logic                       flip_done,
    output logic                       front_page,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic [FBUF_ADDR_WIDTH:0]   bram_addr,
    output logic [PIXEL_WIDTH-1:0]     bram_din,
    input  logic [PIXEL_WIDTH-1:0]     bram_dout
);

    localparam logic [FBUF_ADDR_WIDTH:0] PAGE_LIMIT = (FBUF_ADDR_WIDTH+1)'(PAGE_SIZE);
    localparam int VLD_IDX = (READ_LATENCY >= 2) ? 2 : 1;
    localparam logic DBL = (DOUBLE_BUFFER != 0);

    logic                     bram_en_q, bram_en_d;
    logic                     bram_we_q, bram_we_d;
    logic [FBUF_ADDR_WIDTH:0] bram_addr_q, bram_addr_d;
    logic [PIXEL_WIDTH-1:0]   bram_din_q, bram_din_d;
    logic                     wr_err_q, wr_err_d;
    logic [2:0]               rd_vld_q, rd_vld_d;
    logic                     wr_accept;
    logic                     wr_in_range;

    fbuf_flip_ctrl #(
        .DOUBLE_BUFFER(DOUBLE_BUFFER)
    ) u_flip_ctrl (
        .clk         (clk),
        .rst         (rst),
        .eof         (eof),
        .flip_req    (flip_req),
        .front_page  (front_page),
        .flip_pending(flip_pending),
        .flip_done   (flip_done)
    );

    assign wr_ready    = !rst && !rd_addr_valid;
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_in_range = {1'b0, wr_addr} < PAGE_LIMIT;

    // Page bit comes from front_page in the request cycle, so a flip on the same edge cannot redirect it.
    always_comb begin
        bram_en_d   = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        wr_err_d    = wr_err_q;
        rd_vld_d    = {rd_vld_q[1:0], rd_addr_valid};
        if (rd_addr_valid) begin
            bram_en_d   = 1'b1;
            bram_addr_d = {page_sel(front_page, 1'b0, DBL), rd_addr};
        end else if (wr_accept) begin
            if (wr_in_range) begin
                bram_en_d   = 1'b1;
                bram_we_d   = 1'b1;
                bram_addr_d = {page_sel(front_page, 1'b1, DBL), wr_addr};
                bram_din_d  = wr_data;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            wr_err_q    <= 1'b0;
            rd_vld_q    <= '0;
        end else begin
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            wr_err_q    <= wr_err_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    // rd_vld_q[0] marks the BRAM access cycle; data returns READ_LATENCY stages later.
    assign rd_data_valid = rd_vld_q[VLD_IDX];
    assign rd_data       = rd_data_valid ? bram_dout : '0;

    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_fbuf_port_arbiter.sv
// Directed bench for fbuf_port_arbiter: two instances (read latency 1 and 2) share stimulus; reads are scoreboarded.
module tb_fbuf_port_arbiter;

    localparam int AW = 19;
    localparam int PW = 24;
    localparam int PS = 307200;
    localparam int MEM_DEPTH = 1 << (AW + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, eof, rd_addr_valid, wr_valid, flip_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [PW-1:0] wr_data;

    logic [PW-1:0] rd_data [2];
    logic [PW-1:0] bram_din [2];
    logic [PW-1:0] bram_dout [2];
    logic [AW:0]   bram_addr [2];
    logic          rd_data_valid [2];
    logic          wr_ready [2];
    logic          wr_err [2];
    logic          flip_pending [2];
    logic          flip_done [2];
    logic          front_page [2];
    logic          bram_en [2];
    logic          bram_we [2];

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    logic exp_front;

    typedef struct {
        int            cyc;
        logic [PW-1:0] data;
    } exp_t;

    exp_t          sbq [2][$];
    logic [PW-1:0] ref_mem [0:MEM_DEPTH-1];
    logic [AW-1:0] rda [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] pat(input logic [AW:0] a);
        return (PW'(a) * 24'd13) ^ 24'h5A0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.cyc  = cyc + 2 + k;
            e.data = ref_mem[{exp_front, a}];
            sbq[k].push_back(e);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [PW-1:0] mem [0:MEM_DEPTH-1];
        logic [PW-1:0] s1, s2;

        fbuf_port_arbiter #(
            .FBUF_ADDR_WIDTH(AW),
            .PIXEL_WIDTH    (PW),
            .PAGE_SIZE      (PS),
            .DOUBLE_BUFFER  (1),
            .READ_LATENCY   (k + 1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .rd_addr      (rd_addr),
            .rd_addr_valid(rd_addr_valid),
            .eof          (eof),
            .rd_data      (rd_data[k]),
            .rd_data_valid(rd_data_valid[k]),
            .wr_addr      (wr_addr),
            .wr_data      (wr_data),
            .wr_valid     (wr_valid),
            .wr_ready     (wr_ready[k]),
            .wr_err       (wr_err[k]),
            .flip_req     (flip_req),
            .flip_pending (flip_pending[k]),
            .flip_done    (flip_done[k]),
            .front_page   (front_page[k]),
            .bram_en      (bram_en[k]),
            .bram_we      (bram_we[k]),
            .bram_addr    (bram_addr[k]),
            .bram_din     (bram_din[k]),
            .bram_dout    (bram_dout[k])
        );

        initial begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] = pat((AW+1)'(i));
        end

        always @(posedge clk) begin
            if (bram_en[k] && bram_we[k]) mem[bram_addr[k]] <= bram_din[k];
            s1 <= mem[bram_addr[k]];
            s2 <= s1;
        end
        assign bram_dout[k] = (k == 0) ? s1 : s2;

        always @(negedge clk) begin
            if (mon_en) begin
                if (rd_data_valid[k]) begin
                    checks++;
                    assert (sbq[k].size() > 0) else begin
                        errors++;
                        $error("FAIL rd%0d_unexpected: got valid read expected none (cycle %0d)", k + 1, cyc);
                    end
                    if (sbq[k].size() > 0) begin
                        exp_t e;
                        e = sbq[k].pop_front();
                        chk($sformatf("rd%0d_cycle", k + 1), 64'(cyc), 64'(e.cyc));
                        chk($sformatf("rd%0d_data", k + 1), 64'(rd_data[k]), 64'(e.data));
                    end
                end else begin
                    chk($sformatf("rd%0d_idle_zero", k + 1), 64'(rd_data[k]), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; eof = 1'b1; rd_addr_valid = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; flip_req = 1'b0;
        exp_front = 1'b0;
        rda[0] = 19'd5; rda[1] = 19'd7; rda[2] = 19'd200;
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = pat((AW+1)'(i));

        // reset with eof held high
        repeat (3) step();
        mon_en = 1'b1;
        chk("rst_bram_en", 64'(bram_en[0]), 64'd0);
        chk("rst_bram_we", 64'(bram_we[0]), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr[0]), 64'd0);
        chk("rst_bram_din", 64'(bram_din[0]), 64'd0);
        chk("rst_rd_valid", 64'(rd_data_valid[0]), 64'd0);
        chk("rst_pending", 64'(flip_pending[0]), 64'd0);
        chk("rst_flip_done", 64'(flip_done[0]), 64'd0);
        chk("rst_front", 64'(front_page[0]), 64'd0);
        chk("rst_wr_err", 64'(wr_err[0]), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready[0]), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rel_flip_done", 64'(flip_done[0]), 64'd0);
            chk("rel_front", 64'(front_page[0]), 64'd0);
            chk("rel_bram_en", 64'(bram_en[0]), 64'd0);
        end
        chk("rel_wr_ready", 64'(wr_ready[0]), 64'd1);
        eof = 1'b0;
        step();

        // read beats a simultaneous write
        rd_addr = 19'd100; rd_addr_valid = 1'b1;
        wr_addr = 19'd5; wr_data = 24'hABCDEF; wr_valid = 1'b1;
        push_rd(19'd100);
        #1 chk("prio_wr_ready_blocked", 64'(wr_ready[0]), 64'd0);
        step();
        chk("prio_rd_en", 64'(bram_en[0]), 64'd1);
        chk("prio_rd_we", 64'(bram_we[0]), 64'd0);
        chk("prio_rd_addr", 64'(bram_addr[0]), 64'({1'b0, 19'd100}));
        rd_addr_valid = 1'b0;
        #1 chk("prio_wr_ready_free", 64'(wr_ready[0]), 64'd1);
        step();
        ref_mem[{1'b1, 19'd5}] = 24'hABCDEF;
        chk("prio_wr_en", 64'(bram_en[0]), 64'd1);
        chk("prio_wr_we", 64'(bram_we[0]), 64'd1);
        chk("prio_wr_addr", 64'(bram_addr[0]), 64'({1'b1, 19'd5}));
        chk("prio_wr_din", 64'(bram_din[0]), 64'h00ABCDEF);
        wr_valid = 1'b0;
        step();
        chk("idle_en", 64'(bram_en[0]), 64'd0);
        chk("idle_we", 64'(bram_we[0]), 64'd0);
        chk("idle_addr_hold", 64'(bram_addr[0]), 64'({1'b1, 19'd5}));
        chk("idle_din_hold", 64'(bram_din[0]), 64'h00ABCDEF);

        // back-to-back reads
        for (int a = 0; a < 3; a++) begin
            rd_addr = AW'(a); rd_addr_valid = 1'b1;
            push_rd(AW'(a));
            step();
        end
        rd_addr_valid = 1'b0;
        repeat (5) step();
        chk("burst_drain_l1", 64'(sbq[0].size()), 64'd0);
        chk("burst_drain_l2", 64'(sbq[1].size()), 64'd0);

        // flip armed in the active area, second request ignored
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        chk("flip_pending_armed", 64'(flip_pending[0]), 64'd1);
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        chk("flip_pending_again", 64'(flip_pending[0]), 64'd1);
        chk("flip_done_early", 64'(flip_done[0]), 64'd0);
        repeat (2) step();
        eof = 1'b1;
        wr_valid = 1'b1; wr_addr = 19'd7; wr_data = 24'h123456;
        #1;
        chk("flip_done_at_m", 64'(flip_done[0]), 64'd1);
        chk("flip_pending_at_m", 64'(flip_pending[0]), 64'd1);
        chk("flip_front_at_m", 64'(front_page[0]), 64'd0);
        step();
        ref_mem[{1'b1, 19'd7}] = 24'h123456;
        exp_front = 1'b1;
        wr_valid = 1'b0;
        chk("flip_front_after", 64'(front_page[0]), 64'd1);
        chk("flip_front_after_l2", 64'(front_page[1]), 64'd1);
        chk("flip_pending_after", 64'(flip_pending[0]), 64'd0);
        chk("flip_done_after", 64'(flip_done[0]), 64'd0);
        chk("flip_cycle_wr_addr", 64'(bram_addr[0]), 64'({1'b1, 19'd7}));
        chk("flip_cycle_wr_we", 64'(bram_we[0]), 64'd1);
        repeat (3) begin
            step();
            chk("flip_done_single", 64'(flip_done[0]), 64'd0);
        end
        eof = 1'b0;
        wr_valid = 1'b1; wr_addr = 19'd9; wr_data = 24'h0F0F0F;
        step();
        wr_valid = 1'b0;
        ref_mem[{1'b0, 19'd9}] = 24'h0F0F0F;
        chk("post_flip_wr_addr", 64'(bram_addr[0]), 64'({1'b0, 19'd9}));
        chk("post_flip_wr_we", 64'(bram_we[0]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            rd_addr = rda[i]; rd_addr_valid = 1'b1;
            push_rd(rda[i]);
            step();
            chk("post_flip_rd_addr", 64'(bram_addr[0]), 64'({1'b1, rda[i]}));
        end
        rd_addr_valid = 1'b0;
        repeat (5) step();

        // blanking without an armed flip changes nothing
        eof = 1'b1;
        #1 chk("noarm_flip_done", 64'(flip_done[0]), 64'd0);
        step();
        chk("noarm_front", 64'(front_page[0]), 64'd1);
        eof = 1'b0;
        step();

        // flip request coinciding with the eof rising edge
        eof = 1'b1; flip_req = 1'b1;
        #1 chk("coll_flip_done_now", 64'(flip_done[0]), 64'd0);
        step();
        flip_req = 1'b0;
        chk("coll_pending", 64'(flip_pending[0]), 64'd1);
        chk("coll_front_kept", 64'(front_page[0]), 64'd1);
        repeat (3) begin
            step();
            chk("coll_flip_done_hold", 64'(flip_done[0]), 64'd0);
        end
        eof = 1'b0;
        repeat (2) step();
        eof = 1'b1;
        #1 chk("coll_flip_done_next", 64'(flip_done[0]), 64'd1);
        step();
        exp_front = 1'b0;
        chk("coll_front_after", 64'(front_page[0]), 64'd0);
        chk("coll_pending_after", 64'(flip_pending[0]), 64'd0);
        eof = 1'b0;
        step();

        // out-of-range write
        wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 24'h777777;
        #1;
        chk("range_wr_ready", 64'(wr_ready[0]), 64'd1);
        chk("range_wr_err_before", 64'(wr_err[0]), 64'd0);
        step();
        wr_valid = 1'b0;
        chk("range_bram_en", 64'(bram_en[0]), 64'd0);
        chk("range_wr_err_set", 64'(wr_err[0]), 64'd1);
        wr_valid = 1'b1; wr_addr = 19'd3; wr_data = 24'h000001;
        step();
        wr_valid = 1'b0;
        ref_mem[{1'b1, 19'd3}] = 24'h000001;
        chk("range_next_wr_en", 64'(bram_en[0]), 64'd1);
        chk("range_next_wr_addr", 64'(bram_addr[0]), 64'({1'b1, 19'd3}));
        repeat (3) step();
        chk("range_wr_err_sticky", 64'(wr_err[0]), 64'd1);

        // reset abandons an armed flip and clears wr_err
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        chk("rst_flip_armed", 64'(flip_pending[0]), 64'd1);
        rst = 1'b1;
        step();
        chk("rst2_pending", 64'(flip_pending[0]), 64'd0);
        chk("rst2_wr_err", 64'(wr_err[0]), 64'd0);
        chk("rst2_front", 64'(front_page[0]), 64'd0);
        chk("rst2_bram_addr", 64'(bram_addr[0]), 64'd0);
        rst = 1'b0;
        step();
        eof = 1'b1;
        #1 chk("rst2_no_flip", 64'(flip_done[0]), 64'd0);
        step();
        chk("rst2_front_kept", 64'(front_page[0]), 64'd0);
        eof = 1'b0;
        repeat (3) step();

        chk("final_drain_l1", 64'(sbq[0].size()), 64'd0);
        chk("final_drain_l2", 64'(sbq[1].size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
